// File: rtl/tag_unit.sv
// tag_unit: per-cell tag register with first-responder reduction and ready/valid responder walk
// Optional TAG_COUNT_EN builds a registered population count on resp_count.
module tag_unit #(
  parameter int NUM_CELLS = 32,
  parameter int IDX_W = 5,
  parameter int CNT_W = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_CELLS-1:0] match_lines,
  input  logic [2:0]           op,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic [NUM_CELLS-1:0] tags,
  output logic                 some,
  output logic                 none,
  output logic [IDX_W-1:0]     first_idx,
  output logic                 iter_valid,
  output logic [IDX_W-1:0]     iter_idx,
  input  logic                 iter_ready,
  output logic                 iter_done,
  output logic [CNT_W-1:0]     resp_count
);
  localparam logic [0:0] IDLE = 1'b0, ITER = 1'b1;
  logic [0:0] state;
  logic [NUM_CELLS-1:0] pending, next_tags;
  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_CELLS-1:0] v);
    lowest = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--)
      if (v[i]) lowest = IDX_W'(i);
  endfunction
  // ITERATE and NOP leave the tags untouched
  always_comb
    next_tags = op == 3'd1 ? match_lines :
                op == 3'd2 ? tags & match_lines :
                op == 3'd3 ? tags | match_lines :
                op == 3'd4 ? '0 :
                op == 3'd5 ? '1 :
                op == 3'd6 ? tags & -tags : tags;
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      tags <= '0;
      pending <= '0;
    end else if (state == IDLE) begin
      if (op_valid) begin
        tags <= next_tags;
        if (op == 3'd7) begin
          pending <= tags;
          state <= ITER;
        end
      end
    end else if (pending == '0)
      state <= IDLE;
    else if (iter_ready)
      pending <= pending & (pending - NUM_CELLS'(1));
  assign op_ready = state == IDLE;
  assign some = |tags;
  assign none = ~some;
  assign first_idx = lowest(tags);
  assign iter_valid = state == ITER && pending != '0;
  assign iter_idx = lowest(pending);
  assign iter_done = state == ITER && pending == '0;
`ifdef TAG_COUNT_EN
  logic [CNT_W-1:0] pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CELLS; i++) pop = pop + CNT_W'(tags[i]);
  end
  always_ff @(posedge CLK)
    resp_count <= RST ? '0 : pop;
`else
  assign resp_count = '0;
`endif
endmodule

// File: tb/tb_tag_unit.sv
// tb_tag_unit: scoreboard bench for tag_unit; driver pushes expectations, negedge monitor checks them
module tb_tag_unit;
  localparam int N = 32;
  logic CLK = 0, RST = 1;
  logic [N-1:0] match_lines = '0;
  logic [2:0] op = '0;
  logic op_valid = 0, iter_ready = 1;
  logic op_ready, some, none, iter_valid, iter_done;
  logic [N-1:0] tags;
  logic [4:0] first_idx, iter_idx;
  logic [5:0] resp_count;
  int errors = 0, checks = 0;
  logic [N-1:0] mt = '0, cur = '0, prev = '0;
  logic [N-1:0] tag_q[$];
  int iter_q[$], done_q[$];
  bit mon_en = 0, pend_chk = 0, rdy_rand = 0, rdy_fixed = 1;

  tag_unit dut (
    .CLK(CLK), .RST(RST), .match_lines(match_lines), .op(op), .op_valid(op_valid),
    .op_ready(op_ready), .tags(tags), .some(some), .none(none), .first_idx(first_idx),
    .iter_valid(iter_valid), .iter_idx(iter_idx), .iter_ready(iter_ready),
    .iter_done(iter_done), .resp_count(resp_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int low(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (!op_ready && t < 500) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("idle_timeout", op_ready, 1);
  endtask

  task automatic issue(input logic [2:0] o, input logic [N-1:0] m);
    wait_idle();
    op = o;
    match_lines = m;
    op_valid = 1;
    case (o)
      3'd1: mt = m;
      3'd2: mt = mt & m;
      3'd3: mt = mt | m;
      3'd4: mt = '0;
      3'd5: mt = '1;
      3'd6: mt = mt == '0 ? '0 : N'(1) << low(mt);
      3'd7: begin
        for (int i = 0; i < N; i++) if (mt[i]) iter_q.push_back(i);
        done_q.push_back(1);
      end
      default: ;
    endcase
    tag_q.push_back(mt);
    @(posedge CLK); #1;
    op_valid = 0;
  endtask

  task automatic do_reset();
    RST = 1;
    op_valid = 1;
    op = 3'd1;
    match_lines = '1;
    @(posedge CLK); #1;
    RST = 0;
    op_valid = 0;
    tag_q.delete();
    iter_q.delete();
    done_q.delete();
    mt = '0;
  endtask

  initial forever begin
    @(posedge CLK); #1;
    iter_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  initial forever begin
    @(negedge CLK);
    if (mon_en) begin
      if (pend_chk) cur = tag_q.size() ? tag_q.pop_front() : cur;
      chk("tags", tags, cur);
      chk("some", some, cur != '0);
      chk("none", none, cur == '0);
      chk("first_idx", first_idx, low(cur));
`ifdef TAG_COUNT_EN
      chk("resp_count", resp_count, $countones(prev));
`else
      chk("resp_count", resp_count, 0);
`endif
      if (iter_valid) begin
        chk("iter_unexpected", iter_q.size() == 0, 0);
        if (iter_q.size()) begin
          chk("iter_idx", iter_idx, iter_q[0]);
          if (iter_ready) void'(iter_q.pop_front());
        end
      end
      if (iter_done) begin
        chk("done_unexpected", done_q.size() == 0, 0);
        chk("done_left_idx", iter_q.size(), 0);
        chk("done_valid", iter_valid, 0);
        if (done_q.size()) void'(done_q.pop_front());
      end
      if (RST) begin
        cur = '0;
        prev = '0;
        pend_chk = 0;
      end else begin
        prev = cur;
        pend_chk = op_valid && op_ready;
      end
    end
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    chk("rst_tags", tags, 0);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_iter_valid", iter_valid, 0);
    chk("rst_iter_done", iter_done, 0);
    chk("rst_resp_count", resp_count, 0);
    chk("rst_first_idx", first_idx, 0);
    chk("rst_some", some, 0);
    chk("rst_none", none, 1);
    mon_en = 1;
    issue(3'd1, 32'h0000_00F0);
    issue(3'd0, 32'hFFFF_FFFF);
    issue(3'd2, 32'h0000_0030);
    issue(3'd3, 32'h8000_0000);
    issue(3'd6, 32'h0);
    issue(3'd4, 32'h0);
    issue(3'd5, 32'h0);
    issue(3'd1, 32'h0000_0105);
    issue(3'd7, 32'h0);
    wait_idle();
    chk("iter105_tags", tags, 32'h105);
    issue(3'd1, 32'h0000_000C);
    rdy_fixed = 0;
    issue(3'd7, 32'h0);
    repeat (2) begin @(posedge CLK); #1; end
    op = 3'd1;
    match_lines = 32'hFF;
    op_valid = 1;
    @(posedge CLK); #1;
    op_valid = 0;
    @(posedge CLK); #1;
    chk("stall_tags", tags, 32'h0C);
    chk("stall_valid", iter_valid, 1);
    chk("stall_idx", iter_idx, 2);
    chk("stall_op_ready", op_ready, 0);
    rdy_fixed = 1;
    wait_idle();
    issue(3'd4, 32'h0);
    issue(3'd7, 32'h0);
    wait_idle();
    issue(3'd1, 32'h0000_0105);
    rdy_fixed = 0;
    issue(3'd7, 32'h0);
    repeat (2) begin @(posedge CLK); #1; end
    do_reset();
    chk("midrst_tags", tags, 0);
    chk("midrst_op_ready", op_ready, 1);
    chk("midrst_done", iter_done, 0);
    chk("midrst_valid", iter_valid, 0);
    rdy_fixed = 1;
    rdy_rand = 1;
    for (int k = 0; k < 300; k++)
      issue(3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0 ? N'($urandom) & N'($urandom) & N'($urandom) : N'($urandom));
    rdy_rand = 0;
    wait_idle();
    repeat (3) begin @(posedge CLK); #1; end
    chk("end_tag_q", tag_q.size(), 0);
    chk("end_iter_q", iter_q.size(), 0);
    chk("end_done_q", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tag_unit.md
Name: tag_unit

Overview:
- Parametrised tag register for the content-addressable parallel processor array. One tag bit per cell.
- Tags are loaded or combined from the per-cell match lines. The block reduces the tags to the first responder, or walks all responders one at a time through a ready/valid handshake.
- Reports some/none and the first-responder index to the controller. Sits between the cell match lines and the sequencing controller.

Parameters:
- NUM_CELLS, 32, number of cells/tag bits (>=2)
- IDX_W, 5, width of cell index outputs; must satisfy 2**IDX_W >= NUM_CELLS
- CNT_W, 6, width of responder count; must satisfy 2**CNT_W > NUM_CELLS

Ports:
- CLK  input  1  clock, all state on rising edge
- RST  input  1  synchronous active-high reset
- match_lines  input  NUM_CELLS  per-cell match result from the array
- op  input  3  operation code, see Behaviour
- op_valid  input  1  op present this cycle
- op_ready  output  1  block can accept an op (high only in IDLE)
- tags  output  NUM_CELLS  current tag register
- some  output  1  |tags (combinational from tag register)
- none  output  1  ~some
- first_idx  output  IDX_W  index of lowest set tag; 0 when none
- iter_valid  output  1  iteration presenting a responder index
- iter_idx  output  IDX_W  index of the current responder during iteration
- iter_ready  input  1  consumer accepts iter_idx
- iter_done  output  1  one-cycle pulse at the end of an iteration
- resp_count  output  CNT_W  number of set tags (optional feature)

Behaviour:
- Clock is CLK; reset is synchronous and active-high on RST. One clock domain.
- Reset values:
  - tags=0, pending mask=0, state=IDLE.
  - Outputs: op_ready=1 (after reset), iter_valid=0, iter_done=0, resp_count=0, first_idx=0, some=0, none=1.
- States: IDLE, ITER.
- An op is accepted on an edge where op_valid && op_ready. Its tag update is visible on tags the cycle after acceptance (1-cycle latency). op_valid while not ready is ignored; it is not queued.
- Op codes:
  - 0 NOP: no change.
  - 1 LOAD: tags <= match_lines.
  - 2 AND: tags <= tags & match_lines.
  - 3 OR: tags <= tags | match_lines.
  - 4 CLEAR: tags <= 0.
  - 5 SET_ALL: tags <= all ones.
  - 6 SELECT_FIRST: tags <= only the lowest set bit of tags is kept; no change if none are set.
  - 7 ITERATE: pending <= tags; state -> ITER. tags are unchanged.
- ITER state:
  - op_ready=0.
  - iter_valid = |pending; iter_idx = lowest set bit of pending, or 0 if pending is empty.
  - On iter_valid && iter_ready, that bit of pending is cleared at the edge. The next responder is presented the following cycle, so there is at most one index per cycle.
  - When pending==0 in ITER: iter_done=1 for that cycle, and the state returns to IDLE at the next edge.
  - ITERATE with zero tags: one ITER cycle with iter_valid=0 and iter_done=1, then IDLE.
  - iter_ready low stalls indefinitely; iter_idx stays stable while iter_valid && !iter_ready.
- some, none and first_idx are combinational from the tag register. first_idx uses lowest-index priority.
- RST during ITER: immediate return to IDLE with all registers cleared. No iter_done pulse.
- RST with op_valid in the same cycle: reset wins and the op is dropped.

Optional Feature:
- Macro TAG_COUNT_EN.
- Defined: resp_count is a registered population count of tags, updated every cycle. It is valid one cycle after tags changes, i.e. two cycles after op acceptance.
- Undefined: resp_count is tied to 0 and no popcount logic is built.

Test Plan:
- Reset, then LOAD match_lines=32'h0000_00F0 -> next cycle tags=0x000000F0, some=1, none=0, first_idx=4. With TAG_COUNT_EN, resp_count=4 one cycle later.
- Starting from tags=0xF0, issue AND with 0x0000_0030, then OR with 0x8000_0000 -> tags=0x30 then 0x80000030, first_idx=4 throughout.
- Starting from tags=0x80000030, issue SELECT_FIRST -> tags=0x00000010. CLEAR -> tags=0, none=1, first_idx=0. SET_ALL -> tags=0xFFFFFFFF.
- Starting from tags=0x00000105, issue ITERATE with iter_ready held high -> iter_idx sequence 0, 2, 8 on consecutive cycles, then iter_done pulse, op_ready back high. tags stay 0x105 throughout.
- Starting from tags=0x0C, issue ITERATE with iter_ready low for 3 cycles -> iter_idx stays 2 and iter_valid stays high. An op_valid presented during ITER is ignored (tags stay 0x0C).
- ITERATE with tags=0 -> single cycle of iter_done, iter_valid=0. Separately, RST asserted mid-iteration -> next cycle tags=0, op_ready=1, iter_done=0.
